// File: rtl/lfsr_gen_pkg.sv
// Purpose: shared register map, bit indices, response codes and enums for the LFSR generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_gen_pkg;

    // Byte offsets of the register map
    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_SEED   = 5'h04;
    localparam logic [4:0] ADDR_TAPS   = 5'h08;
    localparam logic [4:0] ADDR_DATA   = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_LOAD   = 1;
    localparam int CTRL_MODE   = 2;
    localparam int CTRL_FLUSH  = 3;
    localparam int CTRL_IRQ_EN = 4;

    // STATUS bit indices ([7:0] is the level)
    localparam int STAT_FULL      = 8;
    localparam int STAT_EMPTY     = 9;
    localparam int STAT_UNDERFLOW = 10;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {MODE_FIB = 1'b0, MODE_GAL = 1'b1} mode_e;
    typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_e;
    typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

    function automatic logic addr_mapped(input logic [4:0] a);
        return (a == ADDR_CTRL) || (a == ADDR_SEED) || (a == ADDR_TAPS) ||
               (a == ADDR_DATA) || (a == ADDR_STATUS);
    endfunction

endpackage

// File: rtl/lfsr_gen_fifo.sv
// Purpose: synchronous FIFO with flush, level, full and empty.
// Latency: push visible at head one cycle later; flush empties on the next edge.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
// Ports: clk/rst, i_push/i_push_dat, i_pop, i_flush, o_head_dat, o_level, o_full, o_empty.
module lfsr_gen_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    // Storage needs no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/lfsr_gen_axi.sv
// Purpose: AXI4-Lite LFSR generator feeding an output FIFO read through the DATA register.
// Latency: B/R responses one cycle after acceptance; LFSR steps one value per cycle into the FIFO.
// Backpressure: LFSR holds while the FIFO is full; bvalid/rvalid hold until bready/rready.
// Ports: clk, rst (sync, active high), AXI4-Lite s_axi_* write/read channels, irq (level).
// Build option LFSR_GEN_GALOIS_EN: enables Galois stepping selected by CTRL[2].
module lfsr_gen_axi
    import lfsr_gen_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               FIFO_DEPTH   = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 'h19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [4:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e        r_wstate;
    rd_state_e        r_rstate;
    logic             r_awready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]       r_bresp, r_rresp;
    logic [31:0]      r_rdata;
    logic             r_enable, r_irq_en, r_load_pend, r_flush_pend;
    logic             r_underflow, r_irq;
    logic [WIDTH-1:0] r_seed, r_taps, r_state;

    logic             w_wr_acc, w_rd_acc, w_pop, w_step, w_mode_bit;
    logic             w_full, w_empty;
    logic [LW-1:0]    w_level;
    logic [WIDTH-1:0] w_head, w_fib, w_next;
    logic [31:0]      w_ctrl_rd, w_status_rd;
    logic             w_unused;

`ifdef LFSR_GEN_GALOIS_EN
    mode_e            r_mode;
    logic [WIDTH-1:0] w_gal;
    assign w_mode_bit = (r_mode == MODE_GAL);
`else
    assign w_mode_bit = 1'b0;
`endif

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign irq           = r_irq;
    assign w_unused      = ^s_axi_wdata;

    // Ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign w_wr_acc = r_awready & s_axi_awvalid & s_axi_wvalid;
    assign w_rd_acc = r_arready & s_axi_arvalid;
    assign w_pop    = w_rd_acc & (s_axi_araddr == ADDR_DATA) & ~w_empty;
    // A pending load or flush owns the cycle, so the LFSR neither steps nor pushes.
    assign w_step   = r_enable & ~w_full & ~r_load_pend & ~r_flush_pend;

    assign w_ctrl_rd   = {27'd0, r_irq_en, 1'b0, w_mode_bit, 1'b0, r_enable};
    assign w_status_rd = {21'd0, r_underflow, w_empty, w_full, 8'(w_level)};

    always_comb begin
        w_fib = {r_state[WIDTH-2:0], ^(r_state & r_taps)};
`ifdef LFSR_GEN_GALOIS_EN
        w_gal  = (r_state >> 1) ^ (r_state[0] ? r_taps : '0);
        w_next = (r_mode == MODE_GAL) ? w_gal : w_fib;
`else
        w_next = w_fib;
`endif
        // All-zero is a lock-up state for both forms; recover to the default seed.
        if (r_state == '0) w_next = DEFAULT_SEED;
    end

    always_ff @(posedge clk) begin
        if (rst)              r_state <= DEFAULT_SEED;
        else if (r_load_pend) r_state <= r_seed;
        else if (w_step)      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate     <= WR_IDLE;
            r_rstate     <= RD_IDLE;
            r_awready    <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rresp      <= RESP_OKAY;
            r_rdata      <= '0;
            r_enable     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_load_pend  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_seed       <= '0;
            r_taps       <= '0;
            r_underflow  <= 1'b0;
            r_irq        <= 1'b0;
`ifdef LFSR_GEN_GALOIS_EN
            r_mode       <= MODE_FIB;
`endif
        end else begin
            r_load_pend  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_irq        <= r_irq_en & (w_level >= LW'(FIFO_DEPTH / 2));

            case (r_wstate)
                WR_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_wr_acc) begin
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_wstate  <= WR_RESP;
                        r_bresp   <= addr_mapped(s_axi_awaddr) ? RESP_OKAY : RESP_SLVERR;
                        case (s_axi_awaddr)
                            ADDR_CTRL: begin
                                r_enable     <= s_axi_wdata[CTRL_EN];
                                r_irq_en     <= s_axi_wdata[CTRL_IRQ_EN];
                                r_load_pend  <= s_axi_wdata[CTRL_LOAD];
                                r_flush_pend <= s_axi_wdata[CTRL_FLUSH];
`ifdef LFSR_GEN_GALOIS_EN
                                r_mode       <= mode_e'(s_axi_wdata[CTRL_MODE]);
`endif
                            end
                            ADDR_SEED:   r_seed      <= s_axi_wdata[WIDTH-1:0];
                            ADDR_TAPS:   r_taps      <= s_axi_wdata[WIDTH-1:0];
                            ADDR_STATUS: r_underflow <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= WR_IDLE;
                    end
                end
                default: r_wstate <= WR_IDLE;
            endcase

            // Read path sits after the write path so an underflow set wins over a same-cycle clear.
            case (r_rstate)
                RD_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_rd_acc) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= RD_DATA;
                        r_rresp   <= RESP_OKAY;
                        r_rdata   <= '0;
                        case (s_axi_araddr)
                            ADDR_CTRL:   r_rdata <= w_ctrl_rd;
                            ADDR_SEED:   r_rdata <= 32'(r_seed);
                            ADDR_TAPS:   r_rdata <= 32'(r_taps);
                            ADDR_DATA: begin
                                if (w_empty) r_underflow <= 1'b1;
                                else         r_rdata     <= 32'(w_head);
                            end
                            ADDR_STATUS: r_rdata <= w_status_rd;
                            default:     r_rresp <= RESP_SLVERR;
                        endcase
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= RD_IDLE;
                    end
                end
                default: r_rstate <= RD_IDLE;
            endcase
        end
    end

    lfsr_gen_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_step),
        .i_push_dat (w_next),
        .i_pop      (w_pop),
        .i_flush    (r_flush_pend),
        .o_head_dat (w_head),
        .o_level    (w_level),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

endmodule
